// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: redirect, instruction-memory and decode-side handshakes of the fetch stage
interface ifetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch with a (pc, instr) queue and redirect flush
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      head, tail, fill, count, unfilled, discard;
  logic [AW+1:0]    inflight;
  logic [31:0]      fpc;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic             req_fire, rsp_ok, pop;
  assign count    = tail - head;
  assign unfilled = tail - fill;
  assign inflight = {1'b0, count} + {1'b0, discard};
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (inflight < (AW+2)'(DEPTH));
  assign bus.imem_req_addr  = fpc;
  assign bus.out_valid      = filled[head[AW-1:0]] && !bus.redirect_valid;
  assign bus.out_pc         = pc_q[head[AW-1:0]];
  assign bus.out_instr      = instr_q[head[AW-1:0]];
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign pop      = bus.out_valid && bus.out_ready;
  assign rsp_ok   = bus.imem_rsp_valid && (discard != '0 || unfilled != '0);
  // Allocate on issue, fill or drop on response, retire on pop; a redirect flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      fill    <= '0;
      discard <= '0;
      filled  <= '0;
      fpc     <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      head    <= '0;
      tail    <= '0;
      fill    <= '0;
      filled  <= '0;
      discard <= discard + unfilled - {{AW{1'b0}}, rsp_ok};
      fpc     <= bus.redirect_pc & ~32'h3;
    end else begin
      if (req_fire) begin
        pc_q[tail[AW-1:0]] <= fpc;
        tail               <= tail + 1'b1;
        fpc                <= fpc + 32'd4;
      end
      if (rsp_ok && discard != '0) discard <= discard - 1'b1;
      if (rsp_ok && discard == '0) begin
        instr_q[fill[AW-1:0]] <= bus.imem_rsp_data;
        filled[fill[AW-1:0]]  <= 1'b1;
        fill                  <= fill + 1'b1;
      end
      if (pop) begin
        filled[head[AW-1:0]] <= 1'b0;
        head                 <= head + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized scoreboard bench for ifetch_queue against a queue-level fetch model
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5A5A5;
  localparam int          NEVER    = 32'h7fffffff;
  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; int fill_cyc; } ent_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0, checks = 0, errors = 0, lat_max = 1;
  mreq_t       mq[$];
  ent_t        exp_q[$];
  logic [31:0] mpc = RESET_PC;
  ifetch_queue_if bif();
  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic reset_checks();
    check("rst_req_valid", 32'(bif.imem_req_valid), 32'd0);
    check("rst_req_addr", bif.imem_req_addr, RESET_PC);
    check("rst_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_out_pc", bif.out_pc, 32'd0);
    check("rst_out_instr", bif.out_instr, 32'd0);
  endtask
  // Stimulus side: memory model tracks accepted requests, expected decode stream is pushed per request
  always @(negedge clk) begin : sb_push
    int    stale;
    int    due;
    bit    done;
    mreq_t e;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      mpc = RESET_PC;
    end else begin
      stale = 0;
      foreach (mq[i]) if (mq[i].stale) stale++;
      check("req_valid", 32'(bif.imem_req_valid), 32'(!bif.redirect_valid && (exp_q.size() + stale < DEPTH)));
      if (bif.imem_rsp_valid && mq.size() > 0) begin
        e = mq.pop_front();
        done = 0;
        if (!e.stale && !bif.redirect_valid)
          foreach (exp_q[i]) if (!done && exp_q[i].fill_cyc == NEVER) begin
            exp_q[i].fill_cyc = cyc;
            done = 1;
          end
      end
      if (bif.redirect_valid) begin
        foreach (mq[i]) mq[i].stale = 1;
        exp_q.delete();
        mpc = bif.redirect_pc & ~32'h3;
      end else if (bif.imem_req_valid && bif.imem_req_ready) begin
        check("req_addr", bif.imem_req_addr, mpc);
        due = cyc + int'($urandom_range(lat_max, 1));
        if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
        mq.push_back('{bif.imem_req_addr, due, 1'b0});
        exp_q.push_back('{mpc, NEVER});
        mpc = mpc + 32'd4;
      end
    end
  end
  // Monitor: compares the presented head against the oldest expected entry and pops on handshake
  always @(negedge clk) begin : monitor
    logic ev;
    #1;
    if (rst_n) begin
      ev = !bif.redirect_valid && exp_q.size() > 0 && exp_q[0].fill_cyc < cyc;
      check("out_valid", 32'(bif.out_valid), 32'(ev));
      if (bif.out_valid && exp_q.size() > 0) begin
        check("out_pc", bif.out_pc, exp_q[0].pc);
        check("out_instr", bif.out_instr, exp_q[0].pc ^ KEY);
        if (bif.out_ready) void'(exp_q.pop_front());
      end
    end
  end
  task automatic step(input int rp, input int op, input int dp, input logic [31:0] tgt, input bit use_tgt);
    @(posedge clk);
    #2;
    bif.imem_req_ready = $urandom_range(99) < rp;
    bif.out_ready      = $urandom_range(99) < op;
    bif.redirect_valid = $urandom_range(99) < dp;
    bif.redirect_pc    = use_tgt ? tgt : ($urandom_range(3) == 0 ? 32'hFFFFFFF8 : $urandom());
    bif.imem_rsp_valid = mq.size() > 0 && mq[0].due <= cyc;
    bif.imem_rsp_data  = bif.imem_rsp_valid ? (mq[0].addr ^ KEY) : $urandom();
  endtask
  initial begin
    bif.redirect_valid = 0;
    bif.redirect_pc    = 0;
    bif.imem_req_ready = 0;
    bif.imem_rsp_valid = 0;
    bif.imem_rsp_data  = 0;
    bif.out_ready      = 0;
    @(posedge clk);
    #2;
    reset_checks();
    @(posedge clk);
    #2;
    rst_n = 1;
    repeat (30) step(100, 100, 0, 0, 0);
    repeat (12) step(100, 0, 0, 0, 0);
    repeat (12) step(100, 100, 0, 0, 0);
    lat_max = 3;
    repeat (2) step(100, 100, 0, 0, 0);
    step(0, 100, 100, 32'h0000_0103, 1);
    repeat (15) step(100, 100, 0, 0, 0);
    lat_max = 1;
    step(0, 100, 100, 32'hFFFF_FFF8, 1);
    repeat (10) step(100, 100, 0, 0, 0);
    lat_max = 4;
    repeat (3000) step(70, 60, 5, 0, 0);
    lat_max = 3;
    repeat (10) step(100, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 0;
    bif.imem_rsp_valid = 0;
    bif.redirect_valid = 0;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    repeat (500) step(80, 70, 4, 0, 0);
    lat_max = 1;
    repeat (40) step(100, 100, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
